prefetch_queue: RTL and testbench

- Instruction prefetch queue that produces the byte window the instruction pre-decoder reads.
- The bus unit writes 16-bit fetch words into the queue.
- The decoder sees the oldest three bytes as q0/q1/q2 and retires a byte count each cycle.
- The queue tracks the fetch IP and the IP of q0, and handles control-transfer flushes, including a bus fetch already in flight.

---
 rtl/prefetch_queue.sv | 131 +++++++++++++
 tb/tb_prefetch_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: collects 16-bit fetch words from the bus unit
// and presents the oldest three bytes (q0..q2) to the instruction pre-decoder.
// Tracks the next fetch address and the IP of q0, and discards a fetch that
// was already in flight when a control transfer flushed the queue.
//
// Storage is a packed byte shifter with q0 in the least significant byte.
// Every byte at or above q_count is kept at zero, which lets a write be
// merged into the shifted contents with a plain OR.
module prefetch_queue #(
    parameter int unsigned DEPTH = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ce,
    input  logic                           flush,
    input  logic [15:0]                    flush_ip,
    output logic                           fetch_req,
    output logic [15:0]                    fetch_ip,
    input  logic                           fetch_ack,
    input  logic [15:0]                    fetch_data,
    input  logic [2:0]                     consume,
    output logic [7:0]                     q0,
    output logic [7:0]                     q1,
    output logic [7:0]                     q2,
    output logic [$clog2(DEPTH+1)-1:0]     q_count,
    output logic [15:0]                    q_ip
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned XW = (CW > 3) ? CW : 3;
    localparam int unsigned MW = DEPTH * 8;

    // Registered state
    logic [MW-1:0] mem_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   fip_q;
    logic [15:0]   qip_q;
    logic          req_q;
    logic          disc_q;

    // Next-state values
    logic [MW-1:0] mem_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [15:0]   fip_nxt;
    logic [15:0]   qip_nxt;
    logic          req_nxt;
    logic          disc_nxt;

    // Datapath intermediates
    logic          ack_v;
    logic [XW-1:0] cons_x;
    logic [XW-1:0] cnt_x;
    logic [XW-1:0] cons_eff;
    logic [CW-1:0] cnt_after;
    logic [1:0]    wr_n;
    logic [15:0]   wr_word;

    // Next-state computation: flush overrides, else consume then write
    always_comb begin
        ack_v     = fetch_ack & req_q;
        cons_x    = XW'(consume);
        cnt_x     = XW'(cnt_q);
        cons_eff  = (cons_x > cnt_x) ? cnt_x : cons_x;
        if (flush) begin
            cons_eff = '0;
        end
        cnt_after = cnt_q - CW'(cons_eff);

        wr_n    = 2'd0;
        wr_word = 16'h0000;
        if (ack_v && !flush && !disc_q) begin
            if (fip_q[0]) begin
                wr_n    = 2'd1;
                wr_word = {8'h00, fetch_data[15:8]};
            end else begin
                wr_n    = 2'd2;
                wr_word = fetch_data;
            end
        end

        mem_nxt  = (mem_q >> {cons_eff, 3'b000})
                 | (MW'(wr_word) << {cnt_after, 3'b000});
        cnt_nxt  = cnt_after + CW'(wr_n);
        fip_nxt  = fip_q + 16'(wr_n);
        qip_nxt  = qip_q + 16'(cons_eff);
        disc_nxt = disc_q;
        if (ack_v) begin
            disc_nxt = 1'b0;
        end

        if (flush) begin
            mem_nxt  = '0;
            cnt_nxt  = '0;
            fip_nxt  = flush_ip;
            qip_nxt  = flush_ip;
            disc_nxt = req_q & ~fetch_ack;
        end

        req_nxt = (cnt_nxt <= CW'(DEPTH - 2)) | disc_nxt;
    end

    // State registers, updated only on clock-enabled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '0;
            cnt_q  <= '0;
            fip_q  <= 16'h0000;
            qip_q  <= 16'h0000;
            req_q  <= 1'b0;
            disc_q <= 1'b0;
        end else if (ce) begin
            mem_q  <= mem_nxt;
            cnt_q  <= cnt_nxt;
            fip_q  <= fip_nxt;
            qip_q  <= qip_nxt;
            req_q  <= req_nxt;
            disc_q <= disc_nxt;
        end
    end

    // Byte window seen by the decoder, zeroed beyond the valid count
    assign q0 = (cnt_q >= CW'(1)) ? mem_q[7:0]   : 8'h00;
    assign q1 = (cnt_q >= CW'(2)) ? mem_q[15:8]  : 8'h00;
    assign q2 = (cnt_q >= CW'(3)) ? mem_q[23:16] : 8'h00;

    assign q_count   = cnt_q;
    assign q_ip      = qip_q;
    assign fetch_ip  = fip_q;
    assign fetch_req = req_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue (DEPTH=6) with hand-computed expectations.
module tb_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        flush;
    logic [15:0] flush_ip;
    logic        fetch_req;
    logic [15:0] fetch_ip;
    logic        fetch_ack;
    logic [15:0] fetch_data;
    logic [2:0]  consume;
    logic [7:0]  q0;
    logic [7:0]  q1;
    logic [7:0]  q2;
    logic [2:0]  q_count;
    logic [15:0] q_ip;

    int n_vec;
    int n_err;

    prefetch_queue #(.DEPTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .flush      (flush),
        .flush_ip   (flush_ip),
        .fetch_req  (fetch_req),
        .fetch_ip   (fetch_ip),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .consume    (consume),
        .q0         (q0),
        .q1         (q1),
        .q2         (q2),
        .q_count    (q_count),
        .q_ip       (q_ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of stimulus, then return the inputs to idle
    task automatic cyc(input logic fl, input logic [15:0] fip, input logic ak,
                       input logic [15:0] d, input logic [2:0] cn);
        flush      = fl;
        flush_ip   = fip;
        fetch_ack  = ak;
        fetch_data = d;
        consume    = cn;
        step();
        flush      = 1'b0;
        fetch_ack  = 1'b0;
        consume    = 3'd0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        ce         = 1'b0;
        flush      = 1'b0;
        flush_ip   = 16'h0000;
        fetch_ack  = 1'b0;
        fetch_data = 16'h0000;
        consume    = 3'd0;
        repeat (2) step();

        // Reset state
        chk("rst_count", 32'(q_count), 32'd0);
        chk("rst_q0", 32'(q0), 32'h00);
        chk("rst_q1", 32'(q1), 32'h00);
        chk("rst_q2", 32'(q2), 32'h00);
        chk("rst_fip", 32'(fetch_ip), 32'h0000);
        chk("rst_qip", 32'(q_ip), 32'h0000);
        chk("rst_req", 32'(fetch_req), 32'd0);

        // 1: one enabled cycle raises the request
        reset = 1'b0;
        ce    = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
        chk("t1_count", 32'(q_count), 32'd0);
        chk("t1_q0", 32'(q0), 32'h00);
        chk("t1_fip", 32'(fetch_ip), 32'h0000);
        chk("t1_req", 32'(fetch_req), 32'd1);

        // 2: odd start address after a fresh reset (no fetch pending)
        reset = 1'b1;
        #1;
        reset = 1'b0;
        chk("t2_rst_req", 32'(fetch_req), 32'd0);
        cyc(1'b1, 16'h0101, 1'b0, 16'h0, 3'd0);
        chk("t2_fl_fip", 32'(fetch_ip), 32'h0101);
        chk("t2_fl_qip", 32'(q_ip), 32'h0101);
        chk("t2_fl_req", 32'(fetch_req), 32'd1);
        cyc(1'b0, 16'h0, 1'b1, 16'hAB12, 3'd0);
        chk("t2_a_count", 32'(q_count), 32'd1);
        chk("t2_a_q0", 32'(q0), 32'hAB);
        chk("t2_a_q1", 32'(q1), 32'h00);
        chk("t2_a_fip", 32'(fetch_ip), 32'h0102);
        chk("t2_a_qip", 32'(q_ip), 32'h0101);
        cyc(1'b0, 16'h0, 1'b1, 16'h3456, 3'd0);
        chk("t2_b_count", 32'(q_count), 32'd3);
        chk("t2_b_q1", 32'(q1), 32'h56);
        chk("t2_b_q2", 32'(q2), 32'h34);
        chk("t2_b_fip", 32'(fetch_ip), 32'h0104);

        // 3: fill to DEPTH, ignored ack, then free two bytes
        cyc(1'b0, 16'h0, 1'b1, 16'h7788, 3'd1);
        chk("t3_a_count", 32'(q_count), 32'd4);
        chk("t3_a_q0", 32'(q0), 32'h56);
        chk("t3_a_qip", 32'(q_ip), 32'h0102);
        chk("t3_a_fip", 32'(fetch_ip), 32'h0106);
        chk("t3_a_req", 32'(fetch_req), 32'd1);
        cyc(1'b0, 16'h0, 1'b1, 16'h9A99, 3'd0);
        chk("t3_b_count", 32'(q_count), 32'd6);
        chk("t3_b_req", 32'(fetch_req), 32'd0);
        chk("t3_b_fip", 32'(fetch_ip), 32'h0108);
        cyc(1'b0, 16'h0, 1'b1, 16'h1111, 3'd0);
        chk("t3_c_count", 32'(q_count), 32'd6);
        chk("t3_c_fip", 32'(fetch_ip), 32'h0108);
        chk("t3_c_q2", 32'(q2), 32'h88);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 3'd2);
        chk("t3_d_count", 32'(q_count), 32'd4);
        chk("t3_d_qip", 32'(q_ip), 32'h0104);
        chk("t3_d_req", 32'(fetch_req), 32'd1);
        chk("t3_d_q0", 32'(q0), 32'h88);
        chk("t3_d_q1", 32'(q1), 32'h77);
        chk("t3_d_q2", 32'(q2), 32'h99);

        // 4: flush with a fetch in flight; consume in the flush cycle is ignored
        cyc(1'b1, 16'h2000, 1'b0, 16'h0, 3'd2);
        chk("t4_fl_count", 32'(q_count), 32'd0);
        chk("t4_fl_qip", 32'(q_ip), 32'h2000);
        chk("t4_fl_fip", 32'(fetch_ip), 32'h2000);
        chk("t4_fl_q0", 32'(q0), 32'h00);
        chk("t4_fl_req", 32'(fetch_req), 32'd1);
        cyc(1'b0, 16'h0, 1'b1, 16'hFFFF, 3'd0);
        chk("t4_drop_count", 32'(q_count), 32'd0);
        chk("t4_drop_fip", 32'(fetch_ip), 32'h2000);
        chk("t4_drop_q0", 32'(q0), 32'h00);
        cyc(1'b0, 16'h0, 1'b1, 16'h2211, 3'd0);
        chk("t4_w_q0", 32'(q0), 32'h11);
        chk("t4_w_q1", 32'(q1), 32'h22);
        chk("t4_w_q2", 32'(q2), 32'h00);
        chk("t4_w_count", 32'(q_count), 32'd2);
        chk("t4_w_fip", 32'(fetch_ip), 32'h2002);

        // 5: simultaneous consume and write, then over-consume clamp
        cyc(1'b0, 16'h0, 1'b1, 16'h4433, 3'd0);
        chk("t5_a_count", 32'(q_count), 32'd4);
        cyc(1'b0, 16'h0, 1'b1, 16'h7766, 3'd3);
        chk("t5_b_count", 32'(q_count), 32'd3);
        chk("t5_b_q0", 32'(q0), 32'h44);
        chk("t5_b_q1", 32'(q1), 32'h66);
        chk("t5_b_q2", 32'(q2), 32'h77);
        chk("t5_b_qip", 32'(q_ip), 32'h2003);
        chk("t5_b_fip", 32'(fetch_ip), 32'h2006);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 3'd5);
        chk("t5_c_count", 32'(q_count), 32'd0);
        chk("t5_c_qip", 32'(q_ip), 32'h2006);
        chk("t5_c_q0", 32'(q0), 32'h00);

        // 6: flush with same-cycle ack (dropped, no discard), wrap, ce gating
        cyc(1'b1, 16'hFFFE, 1'b1, 16'h5555, 3'd0);
        chk("t6_fl_count", 32'(q_count), 32'd0);
        chk("t6_fl_fip", 32'(fetch_ip), 32'hFFFE);
        chk("t6_fl_req", 32'(fetch_req), 32'd1);
        cyc(1'b0, 16'h0, 1'b1, 16'hBBAA, 3'd0);
        chk("t6_w_fip", 32'(fetch_ip), 32'h0000);
        chk("t6_w_qip", 32'(q_ip), 32'hFFFE);
        chk("t6_w_count", 32'(q_count), 32'd2);
        chk("t6_w_q0", 32'(q0), 32'hAA);
        chk("t6_w_q1", 32'(q1), 32'hBB);
        ce         = 1'b0;
        fetch_ack  = 1'b1;
        fetch_data = 16'hDDCC;
        consume    = 3'd1;
        repeat (2) step();
        chk("t6_ce0_count", 32'(q_count), 32'd2);
        chk("t6_ce0_fip", 32'(fetch_ip), 32'h0000);
        chk("t6_ce0_qip", 32'(q_ip), 32'hFFFE);
        chk("t6_ce0_q0", 32'(q0), 32'hAA);
        consume = 3'd0;
        ce      = 1'b1;
        step();
        fetch_ack = 1'b0;
        chk("t6_ce1_count", 32'(q_count), 32'd4);
        chk("t6_ce1_q2", 32'(q2), 32'hCC);
        chk("t6_ce1_fip", 32'(fetch_ip), 32'h0002);

        // 7: reset mid-fetch abandons a pending discard
        cyc(1'b1, 16'h3000, 1'b0, 16'h0, 3'd0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
        chk("t7_req", 32'(fetch_req), 32'd1);
        cyc(1'b0, 16'h0, 1'b1, 16'h0201, 3'd0);
        chk("t7_q0", 32'(q0), 32'h01);
        chk("t7_count", 32'(q_count), 32'd2);
        chk("t7_fip", 32'(fetch_ip), 32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
